// File: rtl/trig_arb_pkg.sv
// trig_arb_pkg: shared types and width helpers for the trigger arbiter.
//   trig_arb_state_t : IDLE / QUAL / HOLD controller states
//   idx_w()          : index width for a requester count
//   cnt_w()          : width of a counter that must hold 0..n
package trig_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    HOLD = 2'd2
  } trig_arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/trig_qual.sv
// trig_qual: clear-on-low saturating run counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the run (start of a new qualification)
//   en       : take a sample this cycle
//   lvl      : raw level sample
//   hit      : this cycle's sample completes DEPTH consecutive highs
module trig_qual
  import trig_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic lvl,
  output logic hit
);

  localparam int CW = cnt_w(DEPTH);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= !lvl ? '0 : (cnt == CW'(DEPTH)) ? cnt : cnt + CW'(1);
  end

  // Hit is judged on the current sample so the arbiter can register
  // trig in the same cycle the DEPTH-th high arrives.
  assign hit = en && lvl && (cnt >= CW'(DEPTH - 1));

endmodule

// File: rtl/trig_arb.sv
// trig_arb: round-robin sharing of one consecutive-high trigger qualifier.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-requester qualification request (level)
//   lvl      : per-requester raw level
//   gnt      : one-hot grant, high throughout QUAL
//   trig     : one-cycle pulse, granted level qualified
//   abort    : one-cycle pulse, withdrawal or timeout
//   trig_id  : index of the requester that last ended QUAL
//   busy     : high in QUAL and HOLD
// Optional: define TRIG_ARB_TIMEOUT_EN to add the qualification timer and
// timeout abort; without it QUAL ends only on hit or withdrawal.
module trig_arb
  import trig_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  parameter int HOLDOFF = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lvl,
  output logic [NREQ-1:0]        gnt,
  output logic                   trig,
  output logic                   abort,
  output logic [idx_w(NREQ)-1:0] trig_id,
  output logic                   busy
);

  localparam int IW = idx_w(NREQ);
  localparam int HW = cnt_w(HOLDOFF);

  trig_arb_state_t state, state_n;
  logic [IW-1:0]   sel, sel_n, last, last_n, id_n, pick;
  logic [NREQ-1:0] gnt_n;
  logic [HW-1:0]   hcnt, hcnt_n;
  logic            trig_n, abort_n, found, qclr, qen, hit;

`ifdef TRIG_ARB_TIMEOUT_EN
  localparam int TW = cnt_w(TIMEOUT);
  logic [TW-1:0] timer, timer_n;
`endif

  trig_qual #(.DEPTH(DEPTH)) u_qual (
    .clk (clk),
    .rst (rst),
    .clr (qclr),
    .en  (qen),
    .lvl (lvl[sel]),
    .hit (hit)
  );

  // Round-robin pick: first set req bit after last, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = last;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[(int'(last) + i) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(last) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    last_n  = last;
    gnt_n   = gnt;
    trig_n  = 1'b0;
    abort_n = 1'b0;
    id_n    = trig_id;
    hcnt_n  = hcnt;
    qclr    = 1'b0;
    qen     = 1'b0;
`ifdef TRIG_ARB_TIMEOUT_EN
    timer_n = timer;
`endif
    case (state)
      IDLE: begin
        qclr = 1'b1;
        if (found) begin
          state_n = QUAL;
          sel_n   = pick;
          gnt_n   = NREQ'(1) << pick;
`ifdef TRIG_ARB_TIMEOUT_EN
          timer_n = '0;
`endif
        end
      end
      QUAL: begin
        qen = 1'b1;
`ifdef TRIG_ARB_TIMEOUT_EN
        timer_n = timer + TW'(1);
`endif
        // Hit outranks withdrawal, which outranks timeout.
        if (hit)
          trig_n = 1'b1;
        else if (!req[sel])
          abort_n = 1'b1;
`ifdef TRIG_ARB_TIMEOUT_EN
        else if (timer_n == TW'(TIMEOUT))
          abort_n = 1'b1;
`endif
        if (trig_n || abort_n) begin
          state_n = HOLD;
          last_n  = sel;
          id_n    = sel;
          gnt_n   = '0;
          hcnt_n  = '0;
        end
      end
      HOLD: begin
        if (hcnt == HW'(HOLDOFF - 1))
          state_n = IDLE;
        else
          hcnt_n = hcnt + HW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      last    <= IW'(NREQ - 1);
      gnt     <= '0;
      trig    <= 1'b0;
      abort   <= 1'b0;
      trig_id <= '0;
      busy    <= 1'b0;
      hcnt    <= '0;
`ifdef TRIG_ARB_TIMEOUT_EN
      timer   <= '0;
`endif
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      last    <= last_n;
      gnt     <= gnt_n;
      trig    <= trig_n;
      abort   <= abort_n;
      trig_id <= id_n;
      busy    <= (state_n != IDLE);
      hcnt    <= hcnt_n;
`ifdef TRIG_ARB_TIMEOUT_EN
      timer   <= timer_n;
`endif
    end
  end

endmodule

// File: tb/tb_trig_arb.sv
module tb_trig_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, lvl, gnt;
  logic       trig, abort, busy;
  logic [1:0] trig_id;

  int n_cmp = 0;
  int n_err = 0;

  trig_arb #(.NREQ(4), .DEPTH(4), .TIMEOUT(16), .HOLDOFF(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lvl     (lvl),
    .gnt     (gnt),
    .trig    (trig),
    .abort   (abort),
    .trig_id (trig_id),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one edge, land 1ns after it.
  task automatic step(input logic [3:0] r, input logic [3:0] l);
    req = r;
    lvl = l;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},  32'(gnt),     0);
    chk({tag, "_trig"}, 32'(trig),    0);
    chk({tag, "_abt"},  32'(abort),   0);
    chk({tag, "_id"},   32'(trig_id), 0);
    chk({tag, "_busy"}, 32'(busy),    0);
  endtask

  int         pat[7] = '{1, 1, 0, 1, 1, 1, 1};
  int         ids[4] = '{0, 1, 3, 0};
  logic [3:0] oh;
  logic       bad;

  initial begin
    rst = 1'b1;
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    rst = 1'b0;
    chk_zero("reset");

    // single requester
    step(4'b0001, 4'b0001);
    chk("single_gnt0", 32'(gnt), 32'h1);
    chk("single_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, 4'b0001);
      chk("single_gnt", 32'(gnt), 32'h1);
      chk("single_early", 32'(trig), 0);
    end
    step(4'b0000, 4'b0001);
    chk("single_trig", 32'(trig), 1);
    chk("single_id", 32'(trig_id), 0);
    chk("single_gnt_off", 32'(gnt), 0);
    step(4'b0000, 4'b0000);
    chk("single_trig_pulse", 32'(trig), 0);
    chk("single_busy_h", 32'(busy), 1);
    step(4'b0000, 4'b0000);
    chk("single_busy_off", 32'(busy), 0);

    // broken run: only the last four highs fire
    step(4'b0001, 4'b0000);
    for (int i = 0; i < 7; i++) begin
      step(4'b0001, (pat[i] != 0) ? 4'b0001 : 4'b0000);
      chk("broken_trig", 32'(trig), (i == 6) ? 1 : 0);
    end
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // round robin from a fresh reset
    rst = 1'b1;
    step(4'b0000, 4'b0000);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << ids[k];
      step(4'b1011, 4'b1111);
      chk("rr_gnt", 32'(gnt), 32'(oh));
      for (int s = 0; s < 3; s++) step(4'b1011, 4'b1111);
      step(4'b1011, 4'b1111);
      chk("rr_trig", 32'(trig), 1);
      chk("rr_id", 32'(trig_id), 32'(ids[k]));
      step(4'b1011, 4'b1111);
      chk("rr_hold_gnt", 32'(gnt), 0);
      step(4'b1011, 4'b1111);
    end
    step(4'b0000, 4'b0000);

    // timeout / no timeout with lvl held low
    step(4'b0100, 4'b0000);
    chk("to_gnt", 32'(gnt), 32'h4);
`ifdef TRIG_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      step(4'b0100, 4'b0000);
      chk("to_early", 32'(abort), 0);
    end
    step(4'b0100, 4'b0000);
    chk("to_abort", 32'(abort), 1);
    chk("to_trig", 32'(trig), 0);
    chk("to_id", 32'(trig_id), 2);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
`else
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(4'b0100, 4'b0000);
      if (abort || trig) bad = 1'b1;
    end
    chk("no_timeout", 32'(bad), 0);
    chk("no_timeout_gnt", 32'(gnt), 32'h4);
    step(4'b0000, 4'b0000);
    chk("wd_abort", 32'(abort), 1);
    chk("wd_id", 32'(trig_id), 2);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
`endif

    // withdraw on the 4th high: hit wins
    step(4'b0010, 4'b0000);
    for (int i = 0; i < 3; i++) step(4'b0010, 4'b0010);
    step(4'b0000, 4'b0010);
    chk("coll_trig", 32'(trig), 1);
    chk("coll_abort", 32'(abort), 0);
    chk("coll_id", 32'(trig_id), 1);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // withdraw on the 2nd sample: abort
    step(4'b0010, 4'b0000);
    step(4'b0010, 4'b0010);
    step(4'b0000, 4'b0010);
    chk("wd2_abort", 32'(abort), 1);
    chk("wd2_trig", 32'(trig), 0);
    chk("wd2_gnt", 32'(gnt), 0);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // reset mid-QUAL
    step(4'b1000, 4'b1000);
    chk("rq_gnt", 32'(gnt), 32'h8);
    rst = 1'b1;
    step(4'b1000, 4'b1000);
    rst = 1'b0;
    chk_zero("rq");
    step(4'b1111, 4'b0000);
    chk("rq_next_gnt", 32'(gnt), 32'h1);
    chk("rq_next_abort", 32'(abort), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
